// File: rtl/spi_multibyte_writer_if.sv
// Byte-stream handshake bundle between a word source, spi_multibyte_writer and the SPI byte core.
// BYTE_COUNT must match the writer instance it is connected to.
interface spi_multibyte_writer_if #(
   parameter int unsigned BYTE_COUNT = 2
);
   logic [BYTE_COUNT*8-1:0] bytes_in;
   logic                    start;
   logic                    cancel;
   logic                    ready;
   logic                    spi_byte_sent;
   logic [7:0]              spi_byte_out;
   logic                    spi_byte_valid;
   logic                    busy;
   logic                    done;

   modport master (
      output bytes_in, start, cancel, spi_byte_sent,
      input  ready, spi_byte_out, spi_byte_valid, busy, done
   );

   modport slave (
      input  bytes_in, start, cancel, spi_byte_sent,
      output ready, spi_byte_out, spi_byte_valid, busy, done
   );
endinterface

// File: rtl/spi_multibyte_writer.sv
// Splits a BYTE_COUNT-byte word into bytes for the SPI transmit core, MSB first by default.
// Define SPI_MULTIBYTE_WRITER_LSB_FIRST_EN to send the least significant byte first.
module spi_multibyte_writer #(
   parameter int unsigned BYTE_COUNT = 2,
   parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
   input logic                   clk,
   input logic                   reset,
   spi_multibyte_writer_if.slave bus
);
   localparam int unsigned W        = BYTE_COUNT * 8;
   localparam logic [7:0]  LAST_IDX = 8'(BYTE_COUNT - 1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e       state_q, state_d;
   logic [7:0]   byte_index_q, byte_index_d;
   logic [W-1:0] shreg_q, shreg_d;
   logic [W-1:0] shreg_adv;
   logic [7:0]   out_q, out_d;
   logic         done_q, done_d;
   logic         last_sent;
   logic         accept;

`ifdef SPI_MULTIBYTE_WRITER_LSB_FIRST_EN
   function automatic logic [7:0] head(input logic [W-1:0] v);
      return v[7:0];
   endfunction
   assign shreg_adv = shreg_q >> 8;
`else
   function automatic logic [7:0] head(input logic [W-1:0] v);
      return v[W-1 -: 8];
   endfunction
   assign shreg_adv = shreg_q << 8;
`endif

   // A start is also taken on the final byte's sent pulse so words stream without a gap.
   assign last_sent = (state_q == SEND) && (byte_index_q == LAST_IDX) && bus.spi_byte_sent;
   assign bus.ready = (state_q == IDLE) || (last_sent && !bus.cancel);
   assign accept    = bus.start && bus.ready && !bus.cancel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_index_q <= '0;
         shreg_q      <= '0;
         out_q        <= IDLE_BYTE;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_index_q <= byte_index_d;
         shreg_q      <= shreg_d;
         out_q        <= out_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      byte_index_d = byte_index_q;
      shreg_d      = shreg_q;
      out_d        = out_q;
      done_d       = 1'b0;
      if (bus.cancel) begin
         state_d      = IDLE;
         byte_index_d = '0;
         shreg_d      = '0;
         out_d        = IDLE_BYTE;
      end else if (accept) begin
         state_d      = SEND;
         byte_index_d = '0;
         shreg_d      = bus.bytes_in;
         out_d        = head(bus.bytes_in);
         done_d       = last_sent;
      end else if (state_q == SEND && bus.spi_byte_sent) begin
         if (byte_index_q == LAST_IDX) begin
            state_d      = IDLE;
            byte_index_d = '0;
            out_d        = IDLE_BYTE;
            done_d       = 1'b1;
         end else begin
            byte_index_d = byte_index_q + 8'd1;
            shreg_d      = shreg_adv;
            out_d        = head(shreg_adv);
         end
      end
   end

   assign bus.spi_byte_out   = out_q;
   assign bus.spi_byte_valid = (state_q == SEND);
   assign bus.busy           = (state_q == SEND);
   assign bus.done           = done_q;
endmodule

// File: tb/tb_spi_multibyte_writer.sv
// Scoreboard bench for spi_multibyte_writer: 2-byte and 3-byte instances, directed words.
// Byte order expectations follow SPI_MULTIBYTE_WRITER_LSB_FIRST_EN.
module tb_spi_multibyte_writer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spi_multibyte_writer_if #(.BYTE_COUNT(2)) b2 ();
   spi_multibyte_writer_if #(.BYTE_COUNT(3)) b3 ();

   spi_multibyte_writer #(.BYTE_COUNT(2), .IDLE_BYTE(8'h00)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
   spi_multibyte_writer #(.BYTE_COUNT(3), .IDLE_BYTE(8'h00)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

   int vecs = 0;
   int errs = 0;
   int done2 = 0;
   int done3 = 0;
   logic [7:0] q2[$];
   logic [7:0] q3[$];
   logic [7:0] e2, e3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input logic [15:0] w);
`ifdef SPI_MULTIBYTE_WRITER_LSB_FIRST_EN
      q2.push_back(w[7:0]);
      q2.push_back(w[15:8]);
`else
      q2.push_back(w[15:8]);
      q2.push_back(w[7:0]);
`endif
   endtask

   task automatic push3(input logic [23:0] w);
      for (int i = 0; i < 3; i++) begin
`ifdef SPI_MULTIBYTE_WRITER_LSB_FIRST_EN
         q3.push_back(w[8*i +: 8]);
`else
         q3.push_back(w[8*(2-i) +: 8]);
`endif
      end
   endtask

   // Monitor: every byte the core consumes must match the next expected byte.
   always @(negedge clk) begin
      if (!reset) begin
         if (b2.spi_byte_sent && b2.spi_byte_valid) begin
            if (q2.size() == 0) begin
               vecs++; errs++;
               $display("FAIL b2 unexpected byte: got %0h, expected none", b2.spi_byte_out);
            end else begin
               e2 = q2.pop_front();
               chk("b2 byte", b2.spi_byte_out, e2);
            end
         end
         if (b3.spi_byte_sent && b3.spi_byte_valid) begin
            if (q3.size() == 0) begin
               vecs++; errs++;
               $display("FAIL b3 unexpected byte: got %0h, expected none", b3.spi_byte_out);
            end else begin
               e3 = q3.pop_front();
               chk("b3 byte", b3.spi_byte_out, e3);
            end
         end
         if (b2.done) done2++;
         if (b3.done) done3++;
      end
   end

   task automatic start2(input logic [15:0] w);
      b2.bytes_in = w;
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      chk("b2 valid one cycle after start", b2.spi_byte_valid, 1);
      chk("b2 busy after start", b2.busy, 1);
   endtask

   task automatic pulse2();
      repeat (3) tick();
      b2.spi_byte_sent = 1'b1;
      tick();
      b2.spi_byte_sent = 1'b0;
   endtask

   task automatic word2(input logic [15:0] w);
      int d0;
      d0 = done2;
      push2(w);
      start2(w);
      pulse2();
      pulse2();
      chk("b2 done after last byte", b2.done, 1);
      chk("b2 busy after word", b2.busy, 0);
      chk("b2 valid after word", b2.spi_byte_valid, 0);
      chk("b2 idle byte after word", b2.spi_byte_out, 8'h00);
      tick();
      chk("b2 done single cycle", b2.done, 0);
      chk("b2 done count per word", done2 - d0, 1);
   endtask

   initial begin
      int d0;
      b2.bytes_in = '0; b2.start = 0; b2.cancel = 0; b2.spi_byte_sent = 0;
      b3.bytes_in = '0; b3.start = 0; b3.cancel = 0; b3.spi_byte_sent = 0;
      #3;
      chk("reset busy", b2.busy, 0);
      chk("reset valid", b2.spi_byte_valid, 0);
      chk("reset out", b2.spi_byte_out, 8'h00);
      chk("reset done", b2.done, 0);
      chk("reset ready", b2.ready, 1);
      chk("reset b3 busy", b3.busy, 0);
      tick();
      reset = 1'b0;
      tick();

      // basic word, pulses 4 cycles apart
      word2(16'hA55A);

      // start while mid-word is ignored
      d0 = done2;
      push2(16'hA55A);
      start2(16'hA55A);
      tick();
      b2.bytes_in = 16'h1111;
      b2.start = 1'b1;
      #1 chk("b2 ready mid-word", b2.ready, 0);
      tick();
      b2.start = 1'b0;
      pulse2();
      pulse2();
      tick();
      chk("b2 one done with ignored start", done2 - d0, 1);

      // cancel after the first byte
      d0 = done2;
      push2(16'hA55A);
      void'(q2.pop_back());
      start2(16'hA55A);
      pulse2();
      b2.cancel = 1'b1;
      tick();
      b2.cancel = 1'b0;
      chk("cancel busy", b2.busy, 0);
      chk("cancel valid", b2.spi_byte_valid, 0);
      chk("cancel idle byte", b2.spi_byte_out, 8'h00);
      chk("cancel ready", b2.ready, 1);
      tick();
      chk("cancel no done", done2 - d0, 0);
      word2(16'hBEEF);

      // cancel coinciding with the final byte's sent pulse
      d0 = done2;
      push2(16'hC33C);
      start2(16'hC33C);
      pulse2();
      repeat (3) tick();
      b2.spi_byte_sent = 1'b1;
      b2.cancel = 1'b1;
      #1 chk("cancel masks ready", b2.ready, 0);
      tick();
      b2.spi_byte_sent = 1'b0;
      b2.cancel = 1'b0;
      chk("cancel on last no done", b2.done, 0);
      chk("cancel on last busy", b2.busy, 0);
      tick();
      chk("cancel on last done count", done2 - d0, 0);

      // cancel and start together in idle
      b2.bytes_in = 16'h7777;
      b2.start = 1'b1;
      b2.cancel = 1'b1;
      tick();
      b2.start = 1'b0;
      b2.cancel = 1'b0;
      chk("cancel beats start", b2.busy, 0);

      // asynchronous reset mid-word
      b2.bytes_in = 16'hA55A;
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async reset busy", b2.busy, 0);
      chk("async reset valid", b2.spi_byte_valid, 0);
      chk("async reset done", b2.done, 0);
      chk("async reset out", b2.spi_byte_out, 8'h00);
      tick();
      reset = 1'b0;
      tick();
      word2(16'h0102);

      // 3-byte back-to-back words with no valid gap
      d0 = done3;
      push3(24'h123456);
      push3(24'hABCDEF);
      b3.bytes_in = 24'h123456;
      b3.start = 1'b1;
      tick();
      b3.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         repeat (3) begin
            chk("b3 valid held", b3.spi_byte_valid, 1);
            tick();
         end
         b3.spi_byte_sent = 1'b1;
         if (k == 2) begin
            b3.bytes_in = 24'hABCDEF;
            b3.start = 1'b1;
            #1 chk("b3 ready on final byte", b3.ready, 1);
         end
         chk("b3 valid at sent", b3.spi_byte_valid, 1);
         tick();
         b3.spi_byte_sent = 1'b0;
         b3.start = 1'b0;
         if (k == 2) chk("b3 done between words", b3.done, 1);
      end
      chk("b3 busy after both words", b3.busy, 0);
      tick();
      chk("b3 two done pulses", done3 - d0, 2);

      chk("b2 queue drained", q2.size(), 0);
      chk("b3 queue drained", q3.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
